alu_serial_seq: RTL

Bit-serial ALU sequencer: accepts a WIDTH-bit operation request and drives a single 1-bit ALU slice for WIDTH cycles, LSB first. It generates the slice's control inputs (ainvert, binvert, cin, s1:s0), holds the carry between bits, and assembles the result and flags. It sits between the instruction/control path and the slice, as the controlling end of the slice's control interface, and trades latency for a one-bit datapath.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_slice.sv | 34 +++
 rtl/alu_serial_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer.
// Opcodes, FSM states, slice controls and the opcode decoder.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_NOR = 3'b100,
        OP_SUB = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_SUM = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic       cin;
        logic [1:0] sel;
    } slice_ctrl_t;

    typedef struct packed {
        slice_ctrl_t ctrl;
        logic        illegal;
    } dec_t;

    // Unknown opcodes decode to AND controls and raise the illegal flag.
    function automatic dec_t decode_op(input op_e op);
        dec_t d;
        d.ctrl    = '{ainvert: 1'b0, binvert: 1'b0, cin: 1'b0, sel: SEL_AND};
        d.illegal = 1'b0;
        case (op)
            OP_AND: d.ctrl.sel = SEL_AND;
            OP_OR:  d.ctrl.sel = SEL_OR;
            OP_ADD: d.ctrl.sel = SEL_SUM;
            OP_XOR: d.ctrl.sel = SEL_XOR;
            OP_SUB: d.ctrl = '{ainvert: 1'b0, binvert: 1'b1, cin: 1'b1, sel: SEL_SUM};
            OP_NOR: d.ctrl = '{ainvert: 1'b1, binvert: 1'b1, cin: 1'b0, sel: SEL_AND};
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice.
// Optional input inversion, then AND/OR/sum/XOR selected by sel.
import alu_pkg::*;

module alu_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] sel,
    output logic       x,
    output logic       cout
);

    logic aa;
    logic bb;

    assign aa = a ^ ainvert;
    assign bb = b ^ binvert;

    // Full-adder carry plus the 4:1 result select.
    always_comb begin
        cout = (aa & bb) | (cin & (aa ^ bb));
        case (sel)
            SEL_AND: x = aa & bb;
            SEL_OR:  x = aa | bb;
            SEL_SUM: x = aa ^ bb ^ cin;
            SEL_XOR: x = aa ^ bb;
            default: x = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer driving one alu_slice, LSB first.
// Holds carry between bits and assembles result and flags.
import alu_pkg::*;

module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_err
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ainv_q, ainv_d;
    logic             binv_q, binv_d;
    logic [1:0]       sel_q, sel_d;
    logic             ill_q, ill_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    dec_t             dec;
    logic             slice_x;
    logic             slice_cout;
    logic             x_eff;
    logic             last;
    logic             is_arith;
    logic [WIDTH-1:0] res_shift;

    assign dec = decode_op(op_e'(req_op));

    alu_slice u_slice (
        .a       (a_q[0]),
        .b       (b_q[0]),
        .cin     (carry_q),
        .ainvert (ainv_q),
        .binvert (binv_q),
        .sel     (sel_q),
        .x       (slice_x),
        .cout    (slice_cout)
    );

    assign x_eff     = ill_q ? 1'b0 : slice_x;
    assign res_shift = {x_eff, res_q[WIDTH-1:1]};
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign is_arith  = !ill_q && (sel_q == SEL_SUM);

    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;
    assign res_zero  = zero_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;
    assign res_err   = err_q;

    // Next-state, operand shifting and flag capture at entry to DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ainv_d  = ainv_q;
        binv_d  = binv_q;
        sel_d   = sel_q;
        ill_d   = ill_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RUN;
                    a_d     = req_a;
                    b_d     = req_b;
                    ainv_d  = dec.ctrl.ainvert;
                    binv_d  = dec.ctrl.binvert;
                    sel_d   = dec.ctrl.sel;
                    ill_d   = dec.illegal;
                    carry_d = dec.ctrl.cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = slice_cout;
                if (last) begin
                    state_d = DONE;
                    zero_d  = (res_shift == '0);
                    cout_d  = is_arith & slice_cout;
                    ovf_d   = is_arith & (carry_q ^ slice_cout);
                    err_d   = ill_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            ainv_q  <= 1'b0;
            binv_q  <= 1'b0;
            sel_q   <= SEL_AND;
            ill_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ainv_q  <= ainv_d;
            binv_q  <= binv_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

endmodule
